// File: rtl/cpu_reg_bank_mp.sv
// Multi-ported CPU register file with an issue scoreboard.
// Register 0 is hardwired to zero. Two write ports are provided, and
// port 1 takes priority when both ports hit the same register.
// NUM_RD combinational read ports can optionally forward same-cycle
// write data. Each register has a busy bit that is set on issue and
// cleared when the register is written. Sticky error flags record
// accesses to x0 and write-port collisions.
module cpu_reg_bank_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        wa0,
    input  logic [DATA_WIDTH-1:0]        wd0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        wa1,
    input  logic [DATA_WIDTH-1:0]        wd1,
    input  logic                         iss_en,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    output logic                         err_x0,
    output logic                         err_wcol
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // Accepted-operation qualifiers. Any access that targets address 0
    // is rejected here, so entry 0 of the storage is never written.
    logic w0_ok;
    logic w1_ok;
    logic iss_ok;
    logic wcol_hit;
    logic x0_hit;

    assign w0_ok    = wen0 && (wa0 != '0);
    assign w1_ok    = wen1 && (wa1 != '0);
    assign iss_ok   = iss_en && (iss_addr != '0);
    assign wcol_hit = w0_ok && w1_ok && (wa0 == wa1);
    assign x0_hit   = (wen0 && (wa0 == '0)) ||
                      (wen1 && (wa1 == '0)) ||
                      (iss_en && (iss_addr == '0));

    // Storage and state. The register file is built from flops rather
    // than block RAM because it must clear on reset and provide
    // combinational, multi-ported reads.
    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;
    logic                  err_x0_reg;
    logic                  err_wcol_reg;

    // One-hot per-register select lines decoded from each port.
    logic [NUM_REGS-1:0] w0_sel;
    logic [NUM_REGS-1:0] w1_sel;
    logic [NUM_REGS-1:0] iss_sel;

    genvar gi;

    // Decode the write and issue targets, and form the next busy state
    // for each register.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
            assign w0_sel[gi]  = w0_ok  && (wa0 == ADDR_WIDTH'(gi));
            assign w1_sel[gi]  = w1_ok  && (wa1 == ADDR_WIDTH'(gi));
            assign iss_sel[gi] = iss_ok && (iss_addr == ADDR_WIDTH'(gi));
            // A same-cycle issue wins over the clear caused by a write,
            // because the newly issued producer is still outstanding.
            assign busy_next[gi] = iss_sel[gi] ||
                                   (busy_reg[gi] && !(w0_sel[gi] || w1_sel[gi]));
        end
    endgenerate

    // Register array update. Port 1 is checked first so that it wins a
    // collision with port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w1_sel[i]) begin
                    regs_reg[i] <= wd1;
                end else if (w0_sel[i]) begin
                    regs_reg[i] <= wd0;
                end
            end
        end
    end

    // Scoreboard update. Reset discards every outstanding busy bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Sticky error flags. Only reset can clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_x0_reg   <= 1'b0;
            err_wcol_reg <= 1'b0;
        end else begin
            err_x0_reg   <= err_x0_reg   || x0_hit;
            err_wcol_reg <= err_wcol_reg || wcol_hit;
        end
    end

    assign err_x0   = err_x0_reg;
    assign err_wcol = err_wcol_reg;

    // Read ports. Every port runs the same lookup independently, so ports
    // that share an address always return the same data and busy flag.
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] addr;
            logic                  fwd1;
            logic                  fwd0;
            logic [DATA_WIDTH-1:0] rd_val;
            logic                  busy_val;

            assign addr = ra[gi*ADDR_WIDTH +: ADDR_WIDTH];
            // w*_ok already excludes address 0, so forwarding can only
            // match a nonzero read address.
            assign fwd1 = (BYPASS != 0) && w1_ok && (wa1 == addr);
            assign fwd0 = (BYPASS != 0) && w0_ok && (wa0 == addr);

            // Select forwarded or stored data. Reads return zero while
            // reset is asserted, so no stale or forwarded value leaks
            // out during the reset cycle.
            always_comb begin
                rd_val   = '0;
                busy_val = 1'b0;
                if (rst || (addr == '0)) begin
                    rd_val   = '0;
                    busy_val = 1'b0;
                end else if (fwd1) begin
                    rd_val   = wd1;
                    busy_val = 1'b0;
                end else if (fwd0) begin
                    rd_val   = wd0;
                    busy_val = 1'b0;
                end else begin
                    rd_val   = regs_reg[addr];
                    busy_val = busy_reg[addr];
                end
            end

            assign rd[gi*DATA_WIDTH +: DATA_WIDTH] = rd_val;
            assign rbusy[gi]                       = busy_val;
        end
    endgenerate

endmodule

// File: tb/tb_cpu_reg_bank_mp.sv
// Testbench for cpu_reg_bank_mp. It drives two instances from shared
// write and issue inputs. Instance a uses the default configuration
// (BYPASS=1, NUM_RD=2). Instance b uses BYPASS=0 and NUM_RD=4. Both
// instances are compared against an array-based reference model.
module tb_cpu_reg_bank_mp;

    logic         clk;
    logic         rst;
    logic [9:0]   ra_a;
    logic [63:0]  rd_a;
    logic [1:0]   rbusy_a;
    logic [19:0]  ra_b;
    logic [127:0] rd_b;
    logic [3:0]   rbusy_b;
    logic         wen0, wen1, iss_en;
    logic [4:0]   wa0, wa1, iss_addr;
    logic [31:0]  wd0, wd1;
    logic         err_x0_a, err_wcol_a, err_x0_b, err_wcol_b;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state.
    logic [31:0] mreg [32];
    bit          mbusy [32];
    bit          merrx;
    bit          mwcol;

    cpu_reg_bank_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .ra(ra_a), .rd(rd_a), .rbusy(rbusy_a),
        .wen0(wen0), .wa0(wa0), .wd0(wd0), .wen1(wen1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .err_x0(err_x0_a), .err_wcol(err_wcol_a)
    );

    cpu_reg_bank_mp #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
        .wen0(wen0), .wa0(wa0), .wd0(wd0), .wen1(wen1), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_en), .iss_addr(iss_addr), .err_x0(err_x0_b), .err_wcol(err_wcol_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (rst || a == 5'd0) return 32'd0;
        if (byp && wen1 && wa1 == a) return wd1;
        if (byp && wen0 && wa0 == a) return wd0;
        return mreg[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
        if (rst || a == 5'd0) return 32'd0;
        if (byp && ((wen1 && wa1 == a) || (wen0 && wa0 == a))) return 32'd0;
        return {31'd0, mbusy[a]};
    endfunction

    function automatic logic [4:0] raddr();
        if ($urandom_range(0, 2) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic idle();
        wen0 = 0; wa0 = 0; wd0 = 0;
        wen1 = 0; wa1 = 0; wd1 = 0;
        iss_en = 0; iss_addr = 0;
        ra_a = '0; ra_b = '0;
    endtask

    // Called shortly after an edge. Compares the combinational read
    // outputs of both instances against the model.
    task automatic settle();
        logic [4:0] a;
        #2;
        for (int p = 0; p < 2; p++) begin
            a = ra_a[p*5 +: 5];
            check($sformatf("a_rd%0d", p), rd_a[p*32 +: 32], exp_rd(a, 1'b1));
            check($sformatf("a_busy%0d", p), {31'd0, rbusy_a[p]}, exp_busy(a, 1'b1));
        end
        for (int p = 0; p < 4; p++) begin
            a = ra_b[p*5 +: 5];
            check($sformatf("b_rd%0d", p), rd_b[p*32 +: 32], exp_rd(a, 1'b0));
            check($sformatf("b_busy%0d", p), {31'd0, rbusy_b[p]}, exp_busy(a, 1'b0));
        end
    endtask

    // Advances one clock edge, applies the edge to the model using the
    // architectural rules, and checks the error flags.
    task automatic tick();
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: rst=%0b w0=%0b/%0d/%h w1=%0b/%0d/%h iss=%0b/%0d",
                 txn, rst, wen0, wa0, wd0, wen1, wa1, wd1, iss_en, iss_addr);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i] = 0;
                mbusy[i] = 0;
            end
            merrx = 0;
            mwcol = 0;
        end else begin
            if (wen0) begin
                if (wa0 == 0) merrx = 1;
                else begin mreg[wa0] = wd0; mbusy[wa0] = 0; end
            end
            if (wen1) begin
                if (wa1 == 0) merrx = 1;
                else begin mreg[wa1] = wd1; mbusy[wa1] = 0; end
            end
            if (wen0 && wen1 && wa0 == wa1 && wa0 != 0) mwcol = 1;
            if (iss_en) begin
                if (iss_addr == 0) merrx = 1;
                else mbusy[iss_addr] = 1;
            end
        end
        check("a_err_x0", {31'd0, err_x0_a}, {31'd0, merrx});
        check("a_err_wcol", {31'd0, err_wcol_a}, {31'd0, mwcol});
        check("b_err_x0", {31'd0, err_x0_b}, {31'd0, merrx});
        check("b_err_wcol", {31'd0, err_wcol_b}, {31'd0, mwcol});
    endtask

    initial begin
        idle();
        rst = 1;
        for (int i = 0; i < 32; i++) begin mreg[i] = 0; mbusy[i] = 0; end
        merrx = 0; mwcol = 0;
        @(posedge clk); #1;

        // Reset.
        settle(); tick();
        check("rst_err_x0", {31'd0, err_x0_a}, 32'd0);
        check("rst_err_wcol", {31'd0, err_wcol_a}, 32'd0);
        rst = 0;

        // Write register 5, then read it back alongside x0.
        wen0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        settle(); tick();
        idle(); ra_a[4:0] = 5; ra_a[9:5] = 0;
        settle();
        check("r030_rd0", rd_a[31:0], 32'hDEADBEEF);
        check("r030_rd1", rd_a[63:32], 32'h0);
        tick();

        // Write collision on register 7: port 1 wins, and the value is forwarded.
        wen0 = 1; wa0 = 7; wd0 = 32'h11; wen1 = 1; wa1 = 7; wd1 = 32'h22; ra_a[4:0] = 7;
        settle();
        check("r031_fwd", rd_a[31:0], 32'h22);
        tick();
        check("r031_wcol", {31'd0, err_wcol_a}, 32'd1);
        idle(); ra_a[4:0] = 7;
        settle();
        check("r031_reg7", rd_a[31:0], 32'h22);
        tick();

        // Issue to register 3, then clear its busy bit with a write.
        iss_en = 1; iss_addr = 3;
        settle(); tick();
        idle(); ra_a[4:0] = 3;
        settle();
        check("r032_busy", {31'd0, rbusy_a[0]}, 32'd1);
        tick();
        wen0 = 1; wa0 = 3; wd0 = 32'h55;
        settle();
        check("r032_busy_byp", {31'd0, rbusy_a[0]}, 32'd0);
        tick();
        idle(); ra_a[4:0] = 3;
        settle();
        check("r032_busy_after", {31'd0, rbusy_a[0]}, 32'd0);
        check("r032_rd", rd_a[31:0], 32'h55);
        tick();

        // Same-cycle issue and write to register 9: the issue wins.
        iss_en = 1; iss_addr = 9; wen0 = 1; wa0 = 9; wd0 = 32'h1;
        settle(); tick();
        idle(); ra_a[4:0] = 9; ra_a[9:5] = 9;
        settle();
        check("r033_rd", rd_a[31:0], 32'h1);
        check("r033_busy", {31'd0, rbusy_a[0]}, 32'd1);
        check("r026_rd_same", rd_a[63:32], 32'h1);
        check("r026_busy_same", {31'd0, rbusy_a[1]}, 32'd1);
        tick();

        // With BYPASS=0, reads show the old value until after the edge.
        wen0 = 1; wa0 = 2; wd0 = 32'hA5; ra_b = {4{5'd2}};
        settle();
        for (int p = 0; p < 4; p++) check($sformatf("r035_old%0d", p), rd_b[p*32 +: 32], 32'h0);
        tick();
        idle(); ra_b = {4{5'd2}};
        settle();
        for (int p = 0; p < 4; p++) check($sformatf("r035_new%0d", p), rd_b[p*32 +: 32], 32'hA5);
        tick();

        // A write to x0 is dropped, and err_x0 stays set until reset.
        wen1 = 1; wa1 = 0; wd1 = 32'hFFFF;
        settle();
        check("r034_x0", rd_a[31:0], 32'h0);
        tick();
        check("r034_err", {31'd0, err_x0_a}, 32'd1);
        idle();
        settle(); tick();
        check("r034_sticky", {31'd0, err_x0_a}, 32'd1);
        rst = 1;
        settle(); tick();
        rst = 0;
        check("r034_err_clr", {31'd0, err_x0_a}, 32'd0);
        ra_a[4:0] = 5;
        settle();
        check("r034_reg5", rd_a[31:0], 32'h0);
        tick();

        // Randomized traffic, with occasional reset.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            wen0     = 1'($urandom_range(0, 1));
            wa0      = raddr();
            wd0      = $urandom();
            wen1     = 1'($urandom_range(0, 1));
            wa1      = raddr();
            wd1      = $urandom();
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = raddr();
            for (int p = 0; p < 2; p++) ra_a[p*5 +: 5] = raddr();
            for (int p = 0; p < 4; p++) ra_b[p*5 +: 5] = raddr();
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_reg_bank_mp.md
CPU_REG_BANK_MP -- requirements
Module: cpu_reg_bank_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width; 2**ADDR_WIDTH registers, index 0 hardwired to zero.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports, legal range 1..4.
REQ-004 SHALL have parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding when 1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ra  input  NUM_RD*ADDR_WIDTH  packed read addresses; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 SHALL have port rd  output  NUM_RD*DATA_WIDTH  packed read data, same packing as ra.
REQ-009 SHALL have port rbusy  output  NUM_RD  per-read-port scoreboard busy flag.
REQ-010 SHALL have ports wen0/wa0/wd0 and wen1/wa1/wd1  input  1/ADDR_WIDTH/DATA_WIDTH  two write ports.
REQ-011 SHALL have ports iss_en/iss_addr  input  1/ADDR_WIDTH  issue port marking a destination register busy.
REQ-012 SHALL have port err_x0  output  1  sticky flag, write or issue to address 0 attempted.
REQ-013 SHALL have port err_wcol  output  1  sticky flag, both write ports targeted the same nonzero address in one cycle.

Function
REQ-014 Read of address 0 SHALL return all zeros and rbusy=0 on every port, regardless of writes.
REQ-015 Read of nonzero address SHALL be combinational: stored value, or per REQ-016 when BYPASS=1.
REQ-016 With BYPASS=1, if wen1 and wa1==ra_i (nonzero) rd_i SHALL equal wd1; else if wen0 and wa0==ra_i, rd_i SHALL equal wd0; with BYPASS=0 rd_i SHALL show the pre-edge stored value.
REQ-017 On rising edge, wen_k with nonzero wa_k SHALL store wd_k into register wa_k; write latency to array is 1 cycle.
REQ-018 Both ports writing the same nonzero address in one cycle: port 1 SHALL win, err_wcol SHALL set on that edge.
REQ-019 Write with wa_k==0 SHALL be discarded and SHALL set err_x0 on that edge.
REQ-020 Scoreboard: one busy bit per nonzero register; iss_en with nonzero iss_addr SHALL set busy[iss_addr] at the edge.
REQ-021 Any accepted write (REQ-017) SHALL clear busy[wa_k] at the edge.
REQ-022 Same-cycle issue and write to the same address: set SHALL win (busy=1 after edge).
REQ-023 iss_en with iss_addr==0 SHALL be ignored and SHALL set err_x0.
REQ-024 rbusy_i SHALL be busy[ra_i]; with BYPASS=1 it SHALL be 0 when a same-cycle write to ra_i is present (REQ-016 forwarding).
REQ-025 err_x0 and err_wcol SHALL remain set until rst; no other clear path.
REQ-026 Multiple read ports addressing the same register SHALL return identical data and busy.

Reset
REQ-027 rst high at rising edge SHALL clear all registers, all busy bits, err_x0 and err_wcol; rst has priority over writes and issues that cycle.
REQ-028 During and after the reset edge, all rd SHALL read 0, all rbusy 0, both error flags 0.
REQ-029 Reset asserted mid-operation SHALL discard pending busy state; first post-reset issue SHALL behave as from clean state.

Verification
REQ-030 Reset, then wen0=1 wa0=5 wd0=0xDEADBEEF; next cycle ra0=5 -> rd0=0xDEADBEEF; ra1=0 -> rd1=0.
REQ-031 BYPASS=1: wen0=1 wa0=7 wd0=0x11, wen1=1 wa1=7 wd1=0x22, ra0=7 -> rd0=0x22 same cycle; after edge reg7=0x22, err_wcol=1.
REQ-032 iss_en addr 3 -> next cycle rbusy for ra=3 is 1; write 3 with 0x55 -> same cycle rbusy=0 (BYPASS=1), next cycle busy=0, rd=0x55.
REQ-033 Same cycle iss_en addr 9 and wen0 wa0=9 wd0=0x1 -> after edge reg9=0x1, busy[9]=1.
REQ-034 wen1=1 wa1=0 wd1=0xFFFF -> ra=0 reads 0, err_x0=1 and stays 1 until rst; rst then clears it and reg5 reads 0.
REQ-035 BYPASS=0, NUM_RD=4: write addr 2 = 0xA5 with all ra=2 -> same cycle rd all old value 0, next cycle all 0xA5.
